life_matrix_scanner: RTL and testbench
======================================

Name: life_matrix_scanner

Overview:
- Downstream consumer of the 64-bit Game-of-Life grid produced by the seed/evolve stage (LFSR or datapath output via the mux).
- Latches a grid at frame boundaries and row-scans it onto an 8x8 LED matrix.
- Emits a generation tick every FRAMES_PER_GEN frames, which paces the upstream evolve step.
- Also reports the live-cell population.

Parameters:
- DWELL_CYCLES, 1000, clocks each row is driven; legal range 2..65535.
- FRAMES_PER_GEN, 30, full frames displayed per generation tick; legal range 1..255.
- BLANK_CYCLES, 4, dark clocks between rows; used only when LED_BLANK_EN is defined; legal range 1..255.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- grid  input  64  cell state; bit index r*8+c is row r, column c; 1 = live.
- grid_valid  input  1  upstream has a grid to present.
- grid_ready  output  1  block accepts grid this cycle.
- pause  input  1  freezes the generation counter; scanning continues.
- row_sel  output  8  one-hot active-high row drive; bit r selects row r.
- col_data  output  8  active-high column data for the selected row.
- gen_tick  output  1  one-cycle pulse requesting the next generation.
- frame_done  output  1  one-cycle pulse on the last cycle of row 7.
- live_count  output  7  population of the displayed frame, 0..64.

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE; row_idx=0; dwell_cnt=0; frame_cnt=0; frame buffer=0.
  - row_sel=0, col_data=0, gen_tick=0, frame_done=0, live_count=0, grid_ready=0.
  - grid_ready rises in the first cycle after reset deasserts.
  - Reset mid-scan abandons the frame immediately; no pulse is emitted.
- States:
  - IDLE: no frame loaded. row_sel=0, col_data=0, grid_ready=1.
  - SCAN: a row is driven.
  - BLANK: only with LED_BLANK_EN.
- Transfer: a grid is taken when grid_valid && grid_ready at a rising edge. It is written to the frame buffer on that edge.
- IDLE -> SCAN on transfer. The next cycle drives row_sel=8'h01 and col_data=buffer[7:0] (1-cycle latency).
- In SCAN:
  - row_sel=1<<row_idx; col_data=buffer[row_idx*8 +: 8].
  - Both are registered outputs; they change only on row changes.
  - dwell_cnt counts 0..DWELL_CYCLES-1. At DWELL_CYCLES-1 it clears and row_idx increments; 7 wraps to 0.
- Frame boundary (row_idx=7 and dwell_cnt=DWELL_CYCLES-1):
  - frame_done=1 and grid_ready=1 for exactly that cycle.
  - grid_ready=0 during SCAN at all other times. The upstream must hold grid_valid until accepted.
  - With a transfer at the boundary: row 0 of the new grid shows next cycle.
  - Without one: row 0 of the old buffer repeats.
- Frame period is 8*DWELL_CYCLES clocks without blanking.
- Generation counter:
  - At each frame boundary with pause=0: frame_cnt increments.
  - If frame_cnt==FRAMES_PER_GEN-1: frame_cnt clears to 0 and gen_tick pulses for one cycle, coincident with frame_done.
  - With pause=1 at the boundary: frame_cnt holds and no gen_tick; frame_done still pulses.
  - FRAMES_PER_GEN=1: gen_tick pulses at every unpaused boundary.
- live_count:
  - Registered popcount of grid, updated on the transfer edge.
  - Valid the cycle after transfer, together with the first row of the new frame.
  - Holds between transfers.
- Simultaneous events:
  - Transfer and gen_tick in the same cycle are independent; both occur.
  - pause toggling mid-frame has no effect until the boundary.
- grid changing while not accepted is ignored; the buffer is untouched.

Optional Feature:
- Macro: LED_BLANK_EN.
- Defined:
  - After every row's dwell, the block enters BLANK for BLANK_CYCLES clocks with row_sel=0 and col_data=0.
  - It then advances to the next row.
  - Frame period becomes 8*(DWELL_CYCLES+BLANK_CYCLES).
  - The frame boundary and grid_ready move to the last BLANK cycle after row 7. frame_done and gen_tick pulse there.
- Undefined: no BLANK state; rows switch back-to-back. BLANK_CYCLES is ignored.

Test Plan (DWELL_CYCLES=4, FRAMES_PER_GEN=2, BLANK_CYCLES=2):
- Load from IDLE: reset low 3 cycles, then high; grid=64'h0000_0000_0000_00FF, grid_valid=1.
  - Next cycle: row_sel=8'h01, col_data=8'hFF, live_count=8.
  - After 4 cycles: row_sel=8'h02, col_data=8'h00.
- Frame and generation pacing: hold grid_valid=0 after the first load.
  - frame_done pulses every 32 cycles; gen_tick pulses on every second frame_done only.
  - grid_ready=1 only on frame_done cycles.
- Pause: assert pause=1 across two boundaries.
  - No gen_tick; frame_done still pulses every 32 cycles.
  - Deassert pause: gen_tick resumes with frame_cnt unchanged.
- Backpressure: present grid=64'hFFFF_FFFF_FFFF_FFFF with grid_valid=1 mid-frame.
  - grid_ready=0 until the boundary; display continues the old data.
  - Accepted at the boundary; next cycle col_data=8'hFF and live_count=64.
- Reset mid-scan: drive reset low during row 3.
  - row_sel, col_data and live_count read 0 immediately, before the next clk edge.
  - No gen_tick or frame_done is emitted.
- LED_BLANK_EN defined:
  - After each 4-cycle row, 2 cycles with row_sel=0 and col_data=0.
  - frame_done period is 48 cycles; it pulses on the last blank cycle after row 7.

Source files
------------

// File: rtl/life_matrix_scanner.sv
// Row-scans a latched 8x8 Game-of-Life grid onto an LED matrix and paces generations.
// Build option: define LED_BLANK_EN to insert dark BLANK_CYCLES clocks between rows.
module life_matrix_scanner #(
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned FRAMES_PER_GEN = 30,
  parameter int unsigned BLANK_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic        grid_ready,
  input  logic        pause,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        gen_tick,
  output logic        frame_done,
  output logic [6:0]  live_count
);

  if (DWELL_CYCLES < 2 || DWELL_CYCLES > 65535) begin : g_bad_dwell
    $error("DWELL_CYCLES out of range");
  end
  if (FRAMES_PER_GEN < 1 || FRAMES_PER_GEN > 255) begin : g_bad_fpg
    $error("FRAMES_PER_GEN out of range");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
    $error("BLANK_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    BLANK
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [7:0]  GEN_LAST   = 8'(FRAMES_PER_GEN - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  row_idx;
  logic [2:0]  row_nxt;
  logic [15:0] dwell_cnt;
  logic [7:0]  frame_cnt;
  logic [63:0] buffer;
  logic        dwell_last;
  logic        row_end;
  logic        boundary;
  logic        take;

  function automatic logic [6:0] popcount(input logic [63:0] g);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, g[i]};
    end
    return n;
  endfunction

  assign dwell_last = (dwell_cnt == DWELL_LAST);
  assign row_nxt    = row_idx + 3'd1;

`ifdef LED_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
  logic [7:0] blank_cnt;
  logic       blank_last;
  assign blank_last = (state == BLANK) && (blank_cnt == BLANK_LAST);
  assign row_end    = blank_last;
`else
  assign row_end    = (state == SCAN) && dwell_last;
`endif

  assign boundary   = row_end && (row_idx == 3'd7);
  assign grid_ready = reset && ((state == IDLE) || boundary);
  assign take       = grid_valid && grid_ready;
  assign frame_done = boundary;
  assign gen_tick   = boundary && !pause && (frame_cnt == GEN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (take) state_nxt = SCAN;
`ifdef LED_BLANK_EN
      SCAN:  if (dwell_last) state_nxt = BLANK;
      BLANK: if (blank_last) state_nxt = SCAN;
`else
      SCAN:  state_nxt = SCAN;
      BLANK: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx    <= '0;
      dwell_cnt  <= '0;
      frame_cnt  <= '0;
      buffer     <= '0;
      row_sel    <= '0;
      col_data   <= '0;
      live_count <= '0;
`ifdef LED_BLANK_EN
      blank_cnt  <= '0;
`endif
    end else begin
      if (state == SCAN) begin
        dwell_cnt <= dwell_last ? 16'd0 : dwell_cnt + 16'd1;
      end
`ifdef LED_BLANK_EN
      if (state == SCAN && dwell_last) begin
        blank_cnt <= '0;
        row_sel   <= '0;
        col_data  <= '0;
      end
      if (state == BLANK) begin
        blank_cnt <= blank_cnt + 8'd1;
      end
`endif
      if (row_end) begin
        row_idx  <= row_nxt;
        row_sel  <= 8'd1 << row_nxt;
        col_data <= buffer[{row_nxt, 3'b000} +: 8];
      end
      if (boundary && !pause) begin
        frame_cnt <= (frame_cnt == GEN_LAST) ? 8'd0 : frame_cnt + 8'd1;
      end
      // New grid overrides the row advance; at a boundary that lands on row 0 anyway.
      if (take) begin
        buffer     <= grid;
        live_count <= popcount(grid);
        row_idx    <= '0;
        dwell_cnt  <= '0;
        row_sel    <= 8'h01;
        col_data   <= grid[7:0];
      end
    end
  end

endmodule

// File: tb/tb_life_matrix_scanner.sv
// Directed bench for life_matrix_scanner: table-driven loads plus a cycle model run.
module tb_life_matrix_scanner;

  localparam int DW  = 4;
  localparam int FPG = 2;
  localparam int BC  = 2;
`ifdef LED_BLANK_EN
  localparam int ROWC = DW + BC;
`else
  localparam int ROWC = DW;
`endif
  localparam int FR = 8 * ROWC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] grid = '0;
  logic        grid_valid = 1'b0;
  logic        grid_ready;
  logic        pause = 1'b0;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        gen_tick;
  logic        frame_done;
  logic [6:0]  live_count;

  int checks = 0;
  int errors = 0;

  life_matrix_scanner #(
    .DWELL_CYCLES  (DW),
    .FRAMES_PER_GEN(FPG),
    .BLANK_CYCLES  (BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .grid      (grid),
    .grid_valid(grid_valid),
    .grid_ready(grid_ready),
    .pause     (pause),
    .row_sel   (row_sel),
    .col_data  (col_data),
    .gen_tick  (gen_tick),
    .frame_done(frame_done),
    .live_count(live_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] g;
    logic [6:0]  cnt;
    logic [7:0]  row0;
    logic [7:0]  row1;
    logic [7:0]  row3;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, " row_sel"}, row_sel, 0);
    check({tag, " col_data"}, col_data, 0);
    check({tag, " live_count"}, live_count, 0);
    check({tag, " grid_ready"}, grid_ready, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " gen_tick"}, gen_tick, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mbuf;
    logic [6:0]  mlc;
    int          fc;
    logic        pend;
    int          kk, row, pos;
    logic [7:0]  er, ec;
    logic        bnd, egt;

    vecs[0] = '{64'h0000_0000_0000_00FF, 7'd8, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 8'hFF, 8'hFF, 8'hFF};
    vecs[2] = '{64'h0000_0000_0000_0000, 7'd0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{64'h8000_0000_0000_0001, 7'd2, 8'h01, 8'h00, 8'h00};
    vecs[4] = '{64'h0000_0000_A500_0000, 7'd4, 8'h00, 8'h00, 8'hA5};
    vecs[5] = '{64'h0123_4567_89AB_CDEF, 7'd32, 8'hEF, 8'hCD, 8'h89};

    for (int v = 0; v < 6; v++) begin
      reset = 1'b0;
      grid_valid = 1'b0;
      repeat (3) tick();
      check_dark("reset");
      reset = 1'b1;
      #1;
      check("idle grid_ready", grid_ready, 1);
      grid = vecs[v].g;
      grid_valid = 1'b1;
      tick();
      grid_valid = 1'b0;
      grid = ~vecs[v].g;
      check("load row_sel", row_sel, 8'h01);
      check("load col_data", col_data, vecs[v].row0);
      check("load live_count", live_count, vecs[v].cnt);
      check("scan grid_ready", grid_ready, 0);
      repeat (ROWC) tick();
      check("row1 row_sel", row_sel, 8'h02);
      check("row1 col_data", col_data, vecs[v].row1);
      repeat (2 * ROWC) tick();
      check("row3 row_sel", row_sel, 8'h08);
      check("row3 col_data", col_data, vecs[v].row3);
      check("row3 live_count", live_count, vecs[v].cnt);
    end

    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    grid = 64'h0000_0000_0000_00FF;
    grid_valid = 1'b1;
    tick();
    grid_valid = 1'b0;
    mbuf = 64'h0000_0000_0000_00FF;
    mlc  = 7'd8;
    fc   = 0;
    pend = 1'b0;

    for (int k = 0; k < 10 * FR + 3 * ROWC + 1; k++) begin
      pause = ((k >= 5 * FR + 5) && (k < 7 * FR + 2)) ||
              ((k >= 9 * FR + 3) && (k < 9 * FR + 6));
      if (k == 8 * FR + 10) pend = 1'b1;
      grid_valid = pend;
      grid = pend ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      #1;
      kk  = k % FR;
      row = kk / ROWC;
      pos = kk % ROWC;
      er  = (pos < DW) ? 8'(1 << row) : 8'h00;
      ec  = (pos < DW) ? mbuf[row*8 +: 8] : 8'h00;
      bnd = (kk == FR - 1);
      egt = bnd && !pause && (fc == FPG - 1);
      check("run row_sel", row_sel, er);
      check("run col_data", col_data, ec);
      check("run frame_done", frame_done, bnd);
      check("run gen_tick", gen_tick, egt);
      check("run grid_ready", grid_ready, bnd);
      check("run live_count", live_count, mlc);
      if (bnd && pend) begin
        mbuf = 64'hFFFF_FFFF_FFFF_FFFF;
        mlc  = 7'd64;
        pend = 1'b0;
      end
      if (bnd && !pause) fc = (fc == FPG - 1) ? 0 : fc + 1;
      tick();
    end

    grid_valid = 1'b0;
    pause = 1'b0;
    check("pre-reset row_sel", row_sel, 8'h08);
    #1;
    reset = 1'b0;
    #1;
    check_dark("async reset");
    repeat (2 * ROWC) begin
      tick();
      check("held reset frame_done", frame_done, 0);
      check("held reset gen_tick", gen_tick, 0);
      check("held reset row_sel", row_sel, 0);
    end
    reset = 1'b1;
    tick();
    check("post-reset row_sel", row_sel, 0);
    check("post-reset grid_ready", grid_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
